uart_rx_buffer: RTL

//  UART receiver (8N1, LSB first) with a small first-word-fall-through FIFO.

---
 rtl/uart_rx_buffer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_buffer.sv
// rtl/uart_rx_buffer.sv - 8N1 UART receiver feeding a small first-word-fall-through FIFO
// Sticky overrun/framing flags record frames that were dropped or arrived corrupt.
module uart_rx_buffer #(
    parameter logic [23:0] CLOCKS_PER_BAUD = 24'd2604,
    parameter int          FIFO_LG         = 2
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_uart_rx,
    input  logic               i_rd,
    input  logic               i_clr_err,
    output logic [7:0]         o_data,
    output logic               o_valid,
    output logic [FIFO_LG:0]   o_count,
    output logic               o_overrun,
    output logic               o_frame_err
);

    localparam int               DEPTH       = 1 << FIFO_LG;
    localparam logic [23:0]      HALF_RELOAD = (CLOCKS_PER_BAUD >> 1) - 24'd1;
    localparam logic [23:0]      FULL_RELOAD = CLOCKS_PER_BAUD - 24'd1;
    localparam logic [FIFO_LG:0] FULL_COUNT  = {1'b1, {FIFO_LG{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    logic               sync1_q;
    logic               rx_s_q;
    state_t             state_q;
    logic [23:0]        baud_q;
    logic [2:0]         bit_idx_q;
    logic [7:0]         shift_q;
    logic               push_q;

    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_LG-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_LG-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_LG:0]   count_q, count_d;
    logic               overrun_q, overrun_d;
    logic               frame_err_q, frame_err_d;

    logic               baud_zero;
    logic               frame_evt;
    logic               pop;
    logic               full;
    logic               wr_en;
    logic               overrun_evt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= i_uart_rx;
            rx_s_q  <= sync1_q;
        end
    end

    assign baud_zero = (baud_q == 24'd0);
    assign frame_evt = (state_q == S_STOP) && baud_zero && !rx_s_q;

    // Leaving STOP at mid-stop-bit lets a following start edge be caught at full baud.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            baud_q    <= 24'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            push_q    <= 1'b0;
        end else begin
            push_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        baud_q  <= HALF_RELOAD;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (baud_zero) begin
                        baud_q <= FULL_RELOAD;
                        if (rx_s_q) begin
                            state_q <= S_IDLE;
                        end else begin
                            bit_idx_q <= 3'd0;
                            state_q   <= S_DATA;
                        end
                    end else begin
                        baud_q <= baud_q - 24'd1;
                    end
                end
                S_DATA: begin
                    if (baud_zero) begin
                        baud_q             <= FULL_RELOAD;
                        shift_q[bit_idx_q] <= rx_s_q;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= S_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        baud_q <= baud_q - 24'd1;
                    end
                end
                S_STOP: begin
                    if (baud_zero) begin
                        baud_q <= FULL_RELOAD;
                        if (rx_s_q) begin
                            push_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= S_BREAK;
                        end
                    end else begin
                        baud_q <= baud_q - 24'd1;
                    end
                end
                S_BREAK: begin
                    if (rx_s_q) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign pop         = i_rd && (count_q != '0);
    assign full        = (count_q == FULL_COUNT);
    assign wr_en       = push_q && (!full || pop);
    assign overrun_evt = push_q && full && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (wr_en && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !wr_en) begin
            count_d = count_q - 1'b1;
        end
        // A new error in the same cycle as the clear keeps the flag set.
        overrun_d   = (overrun_q & ~i_clr_err) | overrun_evt;
        frame_err_d = (frame_err_q & ~i_clr_err) | frame_evt;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    assign o_valid     = (count_q != '0);
    assign o_data      = o_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign o_count     = count_q;
    assign o_overrun   = overrun_q;
    assign o_frame_err = frame_err_q;

endmodule
